// File: rtl/autoconfig_chain.sv
// autoconfig_chain: Zorro III AutoConfig responder presenting NUM_BOARDS
// logical boards in sequence from one physical card.
// Optional feature macro: AUTOBOOT_EN (board 0 advertises an autoboot ROM
// vector at offset 0x0200). Without it every board is a plain I/O board.
module autoconfig_chain #(
    parameter int                        NUM_BOARDS   = 2,
    parameter logic [15:0]               MFG_ID       = 16'd514,
    parameter logic [7:0]                PROD_ID_BASE = 8'd84,
    parameter logic [4*NUM_BOARDS-1:0]   SIZE_CODES   = '0,
    parameter logic [31:0]               SERIAL       = 32'd0,
    parameter int                        DTACK_DELAY  = 1,
    localparam int                       IW           = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      autoconfig_cycle,
    input  logic                      READ,
    input  logic [6:0]                ADDRL,
    input  logic [7:0]                DIN,
    output logic [3:0]                DOUT,
    output logic                      dtack,
    output logic                      CFGOUT_n,
    output logic [8*NUM_BOARDS-1:0]   base_addr,
    output logic [NUM_BOARDS-1:0]     configured,
    output logic [NUM_BOARDS-1:0]     shutup,
    output logic [IW-1:0]             board_idx
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_END} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [3:0]              dout_q, dout_d;
    logic                    dtack_q, dtack_d;
    logic                    cfgout_n_q, cfgout_n_d;
    logic                    adv_q, adv_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              base_q [NUM_BOARDS];
    logic [7:0]              base_d [NUM_BOARDS];
    logic [NUM_BOARDS-1:0]   cfg_q, cfg_d;
    logic [NUM_BOARDS-1:0]   shut_q, shut_d;

    // Chain is finished once the last board has been configured or shut up;
    // CFGOUT_n low and "done" are the same fact.
    logic       done;
    logic       autoboot;
    logic [6:0] nib_idx;
    logic [7:0] prod;
    logic [3:0] rd_nib;
    logic       wr_base, wr_shut;

    assign done = ~cfgout_n_q;

`ifdef AUTOBOOT_EN
    assign autoboot = (idx_q == '0);
`else
    assign autoboot = 1'b0;
`endif

    // Per-board lookup tables, padded to a power of two so any idx is in range.
    logic [3:0] size_tbl [2**IW];
    logic [7:0] prod_tbl [2**IW];
    for (genvar gi = 0; gi < 2**IW; gi++) begin : g_tbl
        if (gi < NUM_BOARDS) begin : g_real
            assign size_tbl[gi] = SIZE_CODES[4*gi +: 4];
        end else begin : g_pad
            assign size_tbl[gi] = 4'h0;
        end
        assign prod_tbl[gi] = PROD_ID_BASE + 8'(gi);
    end

    for (genvar gi = 0; gi < NUM_BOARDS; gi++) begin : g_base
        assign base_addr[8*gi +: 8] = base_q[gi];
    end

    // Config-space read nibble for the board currently answering.
    always_comb begin
        nib_idx = {ADDRL[5:0], ADDRL[6]};
        prod    = prod_tbl[idx_q];
        rd_nib  = 4'hF;
        case (nib_idx)
            7'h00: rd_nib = {3'b100, autoboot};
            7'h01: rd_nib = size_tbl[idx_q];
            7'h02: rd_nib = ~prod[7:4];
            7'h03: rd_nib = ~prod[3:0];
            7'h04: rd_nib = ~4'b0011;
            7'h05: rd_nib = ~4'h0;
            7'h08: rd_nib = ~MFG_ID[15:12];
            7'h09: rd_nib = ~MFG_ID[11:8];
            7'h0A: rd_nib = ~MFG_ID[7:4];
            7'h0B: rd_nib = ~MFG_ID[3:0];
            7'h0C: rd_nib = ~SERIAL[31:28];
            7'h0D: rd_nib = ~SERIAL[27:24];
            7'h0E: rd_nib = ~SERIAL[23:20];
            7'h0F: rd_nib = ~SERIAL[19:16];
            7'h10: rd_nib = ~SERIAL[15:12];
            7'h11: rd_nib = ~SERIAL[11:8];
            7'h12: rd_nib = ~SERIAL[7:4];
            7'h13: rd_nib = ~SERIAL[3:0];
            7'h15: rd_nib = autoboot ? ~4'h2 : 4'hF;
            7'h20: rd_nib = 4'h0;
            7'h21: rd_nib = 4'h0;
            default: rd_nib = 4'hF;
        endcase
    end

    assign wr_base = ~READ && (ADDRL[5:0] == 6'h11);
    assign wr_shut = ~READ && (ADDRL[5:0] == 6'h13);

    // Next-state logic: IDLE -> WAIT -> ACK -> END -> IDLE, abort from WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        dtack_d    = dtack_q;
        cfgout_n_d = cfgout_n_q;
        adv_d      = adv_q;
        idx_d      = idx_q;
        base_d     = base_q;
        cfg_d      = cfg_q;
        shut_d     = shut_q;
        case (state_q)
            S_IDLE: begin
                if (autoconfig_cycle && !done) begin
                    state_d = S_WAIT;
                    dout_d  = rd_nib;
                    cnt_d   = 3'(DTACK_DELAY);
                end
            end
            S_WAIT: begin
                if (!autoconfig_cycle) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 3'd0) begin
                    state_d = S_ACK;
                    dtack_d = 1'b1;
                    adv_d   = wr_base || wr_shut;
                    for (int k = 0; k < NUM_BOARDS; k++) begin
                        if (idx_q == IW'(k)) begin
                            if (wr_base) begin
                                base_d[k] = DIN;
                                cfg_d[k]  = 1'b1;
                            end
                            if (wr_shut) begin
                                shut_d[k] = 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                if (!autoconfig_cycle) begin
                    state_d = S_END;
                    dtack_d = 1'b0;
                end
            end
            S_END: begin
                state_d = S_IDLE;
                adv_d   = 1'b0;
                if (adv_q) begin
                    if (idx_q == IW'(NUM_BOARDS - 1)) begin
                        cfgout_n_d = 1'b0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset of every output and flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            dout_q     <= 4'h0;
            dtack_q    <= 1'b0;
            cfgout_n_q <= 1'b1;
            adv_q      <= 1'b0;
            idx_q      <= '0;
            cfg_q      <= '0;
            shut_q     <= '0;
            for (int k = 0; k < NUM_BOARDS; k++) begin
                base_q[k] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            dtack_q    <= dtack_d;
            cfgout_n_q <= cfgout_n_d;
            adv_q      <= adv_d;
            idx_q      <= idx_d;
            cfg_q      <= cfg_d;
            shut_q     <= shut_d;
            base_q     <= base_d;
        end
    end

    assign DOUT       = dout_q;
    assign dtack      = dtack_q;
    assign CFGOUT_n   = cfgout_n_q;
    assign configured = cfg_q;
    assign shutup     = shut_q;
    assign board_idx  = idx_q;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Directed bench for autoconfig_chain: two-board chain (DTACK_DELAY=1) plus a
// second instance with DTACK_DELAY=3 for the aborted-cycle case.
module tb_autoconfig_chain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        cyc3 = 1'b0;
    logic        rd = 1'b1;
    logic [6:0]  addr = 7'h00;
    logic [7:0]  din = 8'h00;

    logic [3:0]  dout, dout3;
    logic        dtack, dtack3;
    logic        cfgout_n, cfgout_n3;
    logic [15:0] base_addr, base_addr3;
    logic [1:0]  configured, configured3;
    logic [1:0]  shutup, shutup3;
    logic [0:0]  board_idx, board_idx3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    autoconfig_chain #(.NUM_BOARDS(2), .SIZE_CODES(8'h37), .DTACK_DELAY(1)) dut (
        .CLK(clk), .RESET(rst), .autoconfig_cycle(cyc), .READ(rd), .ADDRL(addr),
        .DIN(din), .DOUT(dout), .dtack(dtack), .CFGOUT_n(cfgout_n),
        .base_addr(base_addr), .configured(configured), .shutup(shutup),
        .board_idx(board_idx)
    );

    autoconfig_chain #(.NUM_BOARDS(2), .DTACK_DELAY(3)) dut3 (
        .CLK(clk), .RESET(rst), .autoconfig_cycle(cyc3), .READ(rd), .ADDRL(addr),
        .DIN(din), .DOUT(dout3), .dtack(dtack3), .CFGOUT_n(cfgout_n3),
        .base_addr(base_addr3), .configured(configured3), .shutup(shutup3),
        .board_idx(board_idx3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Start a cycle at a falling edge; report edges until dtack (0 = none in 20)
    // and DOUT one edge after the cycle was first sampled.
    task automatic start_cycle(input logic r, input logic [6:0] a, input logic [7:0] d,
                               output int edges, output logic [3:0] d1);
        rd    = r;
        addr  = a;
        din   = d;
        cyc   = 1'b1;
        edges = 0;
        d1    = 4'h0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) d1 = dout;
            if (dtack) begin
                edges = i;
                break;
            end
        end
    endtask

    // Drop the cycle; report dtack one edge later, then allow the END edge.
    task automatic end_cycle(output logic dt);
        cyc = 1'b0;
        @(negedge clk);
        dt = dtack;
        @(negedge clk);
    endtask

    int         edges;
    logic [3:0] d1;
    logic       dt;
    logic       seen3;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_dtack", 32'(dtack), 32'h0);
        check("rst_cfgout_n", 32'(cfgout_n), 32'h1);
        check("rst_base", 32'(base_addr), 32'h0);
        check("rst_configured", 32'(configured), 32'h0);
        check("rst_shutup", 32'(shutup), 32'h0);
        check("rst_board_idx", 32'(board_idx), 32'h0);

        // Aborted 0x11 write on the DTACK_DELAY=3 instance.
        rd = 1'b0; addr = 7'h11; din = 8'hAA; cyc3 = 1'b1; seen3 = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen3 = seen3 | dtack3;
        end
        cyc3 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen3 = seen3 | dtack3;
        end
        check("abort_dtack_never", 32'(seen3), 32'h0);
        check("abort_configured", 32'(configured3), 32'h0);
        check("abort_board_idx", 32'(board_idx3), 32'h0);
        check("abort_base", 32'(base_addr3), 32'h0);

        // Board 0 reads (nibble index n -> ADDRL = {n[0], n[6:1]}).
        start_cycle(1'b1, 7'h01, 8'h00, edges, d1);
        check("b0_rd02_dout", 32'(d1), 32'hA);
        check("b0_rd02_latency", 32'(edges), 32'd3);
        end_cycle(dt);
        check("b0_rd02_dtack_fall", 32'(dt), 32'h0);

        start_cycle(1'b1, 7'h00, 8'h00, edges, d1);
`ifdef AUTOBOOT_EN
        check("b0_rd00_type", 32'(d1), 32'h9);
`else
        check("b0_rd00_type", 32'(d1), 32'h8);
`endif
        end_cycle(dt);

        start_cycle(1'b1, 7'h4A, 8'h00, edges, d1);
`ifdef AUTOBOOT_EN
        check("b0_rd15_rom", 32'(d1), 32'hD);
`else
        check("b0_rd15_rom", 32'(d1), 32'hF);
`endif
        end_cycle(dt);

        start_cycle(1'b1, 7'h40, 8'h00, edges, d1);
        check("b0_rd01_size", 32'(d1), 32'h7);
        end_cycle(dt);
        start_cycle(1'b1, 7'h04, 8'h00, edges, d1);
        check("b0_rd08_mfg", 32'(d1), 32'hF);
        end_cycle(dt);
        start_cycle(1'b1, 7'h44, 8'h00, edges, d1);
        check("b0_rd09_mfg", 32'(d1), 32'hD);
        end_cycle(dt);
        start_cycle(1'b1, 7'h02, 8'h00, edges, d1);
        check("b0_rd04_flags", 32'(d1), 32'hC);
        end_cycle(dt);
        start_cycle(1'b1, 7'h10, 8'h00, edges, d1);
        check("b0_rd20_zero", 32'(d1), 32'h0);
        end_cycle(dt);
        start_cycle(1'b1, 7'h18, 8'h00, edges, d1);
        check("b0_rd30_unused", 32'(d1), 32'hF);
        end_cycle(dt);

        // Configure board 0 at 0x40.
        start_cycle(1'b0, 7'h11, 8'h40, edges, d1);
        check("b0_wr11_latency", 32'(edges), 32'd3);
        check("b0_wr11_base_in_ack", 32'(base_addr), 32'h0040);
        end_cycle(dt);
        check("b0_wr11_base", 32'(base_addr), 32'h0040);
        check("b0_wr11_configured", 32'(configured), 32'h1);
        check("b0_wr11_board_idx", 32'(board_idx), 32'h1);
        check("b0_wr11_cfgout_n", 32'(cfgout_n), 32'h1);

        // Board 1 reads.
        start_cycle(1'b1, 7'h41, 8'h00, edges, d1);
        check("b1_rd03_dout", 32'(d1), 32'hA);
        end_cycle(dt);
        start_cycle(1'b1, 7'h40, 8'h00, edges, d1);
        check("b1_rd01_size", 32'(d1), 32'h3);
        end_cycle(dt);
        start_cycle(1'b1, 7'h00, 8'h00, edges, d1);
        check("b1_rd00_type", 32'(d1), 32'h8);
        end_cycle(dt);

        // Shut up board 1 -> chain done.
        start_cycle(1'b0, 7'h13, 8'h00, edges, d1);
        check("b1_wr13_latency", 32'(edges), 32'd3);
        end_cycle(dt);
        check("b1_wr13_shutup", 32'(shutup), 32'h2);
        check("b1_wr13_cfgout_n", 32'(cfgout_n), 32'h0);
        check("b1_wr13_configured", 32'(configured), 32'h1);

        // Chain done: further cycle is ignored.
        start_cycle(1'b1, 7'h01, 8'h00, edges, d1);
        check("done_no_dtack", 32'(edges), 32'd0);
        check("done_dout_held", 32'(dout), 32'hF);
        end_cycle(dt);

        // Reset during ACK of a 0x11 write on board 1.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_cycle(1'b0, 7'h11, 8'h12, edges, d1);
        end_cycle(dt);
        check("rst2_board_idx_pre", 32'(board_idx), 32'h1);
        start_cycle(1'b0, 7'h11, 8'h55, edges, d1);
        check("rst2_in_ack", 32'(dtack), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_dtack", 32'(dtack), 32'h0);
        check("rst2_configured", 32'(configured), 32'h0);
        check("rst2_board_idx", 32'(board_idx), 32'h0);
        check("rst2_cfgout_n", 32'(cfgout_n), 32'h1);
        check("rst2_base", 32'(base_addr), 32'h0);
        rst = 1'b0;
        cyc = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_board_idx_after", 32'(board_idx), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/autoconfig_chain.md
# autoconfig_chain

Zorro III AutoConfig responder that presents `NUM_BOARDS` logical boards in sequence from one physical card. Each board is a separate entry in the chain with its own product ID, size code and base address. It sits between the bus-cycle decoder, which supplies `autoconfig_cycle`, ADDRL and DIN, and the address comparators, which consume `base_addr`/`configured`. It drives the nibble-wide config read data, a delayed DTACK and the chain's CFGOUT_n.

## Interface
Parameters:
- `NUM_BOARDS`, default 2: logical boards in the chain, legal range 1–4.
- `MFG_ID`, default 16'd514: manufacturer ID, shared by all boards.
- `PROD_ID_BASE`, default 8'd84: board *k* reports product `PROD_ID_BASE + k`, mod 256.
- `SIZE_CODES`, default 8'h00: packed 4 bits per board, board *k* at `[4k+3:4k]`; this is the er_Type size nibble.
- `SERIAL`, default 32'd0: serial number, shared by all boards.
- `DTACK_DELAY`, default 1: wait cycles between DOUT valid and DTACK, range 0–7.

Ports (clock and reset first; one clock, reset is synchronous and active-high):
- `CLK` in 1: system clock; all state changes on the rising edge.
- `RESET` in 1: synchronous active-high reset.
- `autoconfig_cycle` in 1: high for the whole duration of a config-space bus cycle.
- `READ` in 1: 1 = read, 0 = write; sampled while `autoconfig_cycle` is high.
- `ADDRL` in 7: config register address; nibble index is `{ADDRL[5:0],ADDRL[6]}`.
- `DIN` in 8: write data.
- `DOUT` out 4: read nibble, registered.
- `dtack` out 1: cycle acknowledge, registered.
- `CFGOUT_n` out 1: chain output; low once every board is configured or shut up.
- `base_addr` out 8·NUM_BOARDS: latched A31..A24 per board.
- `configured` out NUM_BOARDS: per-board configured flag.
- `shutup` out NUM_BOARDS: per-board shut-up flag.
- `board_idx` out clog2(NUM_BOARDS), minimum 1 bit: board currently answering.

## Operation
- Reset values: DOUT=0, dtack=0, CFGOUT_n=1, base_addr=0, configured=0, shutup=0, board_idx=0, state=IDLE, wait counter=0.
- `done` = board_idx has advanced past the last board. Once `done` is set the block ignores all cycles: dtack stays 0 and DOUT is held.
- FSM states:
  - IDLE → WAIT when `autoconfig_cycle`=1 and not `done`. On this edge DOUT is loaded, and the wait counter is loaded with DTACK_DELAY.
  - WAIT: the counter decrements each cycle. When it reaches 0, go to ACK.
  - WAIT → IDLE if `autoconfig_cycle` drops. The cycle is aborted: no write side-effect, dtack never rises.
  - ACK: dtack=1 on entry. Write side-effects are applied on the entry edge, with DIN sampled on that edge. ACK holds while `autoconfig_cycle`=1.
  - ACK → END when `autoconfig_cycle`=0. On this edge dtack=0.
  - END: for one cycle, advance board_idx if the ACKed cycle was a 0x11 or 0x13 write. Update CFGOUT_n, then go to IDLE.
- Read map for the current board *k*; all values inverted except 0x00, 0x01, 0x20, 0x21:
  - 0x00: type nibble, `{1,0,0,AB}`, where AB is the autoboot bit (see Configuration).
  - 0x01: `SIZE_CODES[k]`.
  - 0x02/0x03: product hi/lo nibble.
  - 0x04: ~4'b0011.
  - 0x05: ~0.
  - 0x08–0x0B: MFG_ID nibbles, MSB first.
  - 0x0C–0x13: SERIAL nibbles, MSB first.
  - 0x14–0x17: ROM vector.
  - 0x20/0x21: 0.
  - Anything else: 4'hF.
- Writes to ADDRL[5:0]:
  - 0x11: `base_addr[k]`←DIN, `configured[k]`←1.
  - 0x13: `shutup[k]`←1.
  - All other writes are acknowledged with no effect.
  - A second write to the same board before END is accepted; last value wins.
- CFGOUT_n goes 0 at the END edge in which board_idx passes NUM_BOARDS−1. It stays 0 until reset.

## Timing
- Reads: `autoconfig_cycle` is first sampled high at edge E. DOUT is valid after E. dtack rises after edge E+1+DTACK_DELAY.
- dtack falls on the first edge that samples `autoconfig_cycle`=0.
- Minimum cycle-to-cycle gap: END plus IDLE sampling, i.e. 2 clocks after dtack falls.
- RESET asserted in any state returns every output to its reset value on that edge, including mid-ACK. Any pending advance is lost.

## Configuration
- `AUTOBOOT_EN` defined:
  - Board 0 type nibble = 4'b1001.
  - Board 0 ROM vector reads ~0,~2,~0,~0, i.e. offset 0x0200.
  - Other boards behave as when the macro is undefined.
- `AUTOBOOT_EN` undefined:
  - All boards report type 4'b1000.
  - 0x14–0x17 read 4'hF.

## Test plan
- NUM_BOARDS=2, DTACK_DELAY=1: read 0x02 on board 0 → DOUT=~5=4'hA. dtack rises 2 edges after the cycle starts.
- Write DIN=8'h40 at 0x11, then end the cycle → base_addr[7:0]=8'h40, configured=2'b01, board_idx=1, CFGOUT_n=1. Then read 0x03 → DOUT=~5=4'hA (product 85, lo nibble 5).
- Board 1: write 0x13 → shutup=2'b10, CFGOUT_n=0 after END. A further read gets no dtack for 20 clocks.
- Drop `autoconfig_cycle` during WAIT with DTACK_DELAY=3 on a 0x11 write → configured unchanged, dtack never 1, board_idx unchanged.
- Assert RESET during ACK of a 0x11 write on board 1 → next edge: dtack=0, configured=0, board_idx=0, CFGOUT_n=1.
- With `AUTOBOOT_EN`: board 0 reads 0x00=4'b1001 and 0x15=4'hD. Without it: 0x00=4'b1000 and 0x15=4'hF.
